pe_mac_param: RTL and testbench

//  Parametrised systolic-array processing element, successor to the fixed-width MAC PE.
//  - Forwards A (east) and B (south) operands with one register stage.
//  - Accumulates A*B products into a wide accumulator. Signed or unsigned; optional saturation.
//  - Adds operand valids and a global enable (stall).
//  - Tile results go into a local drain FIFO with a valid/ready handshake, so the drain network can backpressure.

---
 rtl/pe_mac_param.sv | 122 ++++++++++++
 tb/tb_pe_mac_param.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_mac_param.sv
// pe_mac_param: parametrised systolic MAC PE with operand forwarding, saturation and a drain FIFO
module pe_mac_param #(
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 24,
  parameter bit SIGNED      = 1,
  parameter bit SATURATE    = 1,
  parameter int DRAIN_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] a_data_i,
  input  logic                  a_valid_i,
  input  logic                  a_last_i,
  input  logic [DATA_WIDTH-1:0] b_data_i,
  input  logic                  b_valid_i,
  input  logic                  b_last_i,
  output logic [DATA_WIDTH-1:0] a_data_o,
  output logic                  a_valid_o,
  output logic                  a_last_o,
  output logic [DATA_WIDTH-1:0] b_data_o,
  output logic                  b_valid_o,
  output logic                  b_last_o,
  output logic [ACC_WIDTH-1:0]  drain_data_o,
  output logic                  drain_ovf_o,
  output logic                  drain_valid_o,
  input  logic                  drain_ready_i,
  output logic                  full_o,
  output logic                  err_o
);
  localparam int PW = DRAIN_DEPTH > 1 ? $clog2(DRAIN_DEPTH) : 1;
  localparam int CW = $clog2(DRAIN_DEPTH + 1);
  localparam int MSB = ACC_WIDTH - 1;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic                   r_fresh;
  logic                   r_ovf;
  logic                   r_err;
  logic [ACC_WIDTH-1:0]   r_mem [DRAIN_DEPTH];
  logic [DRAIN_DEPTH-1:0] r_mem_ovf;
  logic [PW-1:0]          r_wptr;
  logic [PW-1:0]          r_rptr;
  logic [CW-1:0]          r_cnt;
  logic                   w_fire;
  logic                   w_close;
  logic                   w_pop;
  logic                   w_push_ok;
  logic                   w_drop;
  logic                   w_mismatch;
  logic signed [ACC_WIDTH-1:0] w_ext_s;
  logic [ACC_WIDTH-1:0]   w_ext_u;
  logic [ACC_WIDTH-1:0]   w_prod;
  logic [ACC_WIDTH-1:0]   w_base;
  logic [ACC_WIDTH:0]     w_sum;
  logic [ACC_WIDTH-1:0]   w_res;
  logic                   w_ovf;
  logic                   w_tile_ovf;
  always_comb begin
    w_fire        = en_i & a_valid_i & b_valid_i;
    w_close       = w_fire & a_last_i & b_last_i;
    w_mismatch    = w_fire & (a_last_i ^ b_last_i);
    drain_valid_o = r_cnt != '0;
    full_o        = r_cnt == CW'(DRAIN_DEPTH);
    drain_data_o  = r_mem[r_rptr];
    drain_ovf_o   = r_mem_ovf[r_rptr];
    err_o         = r_err;
    w_pop         = drain_valid_o & drain_ready_i;
    w_push_ok     = w_close & (!full_o | w_pop);
    w_drop        = w_close & full_o & !w_pop;
    w_ext_s       = $signed(a_data_i) * $signed(b_data_i);
    w_ext_u       = a_data_i * b_data_i;
    w_prod        = SIGNED ? w_ext_s : w_ext_u;
    w_base        = r_fresh ? '0 : r_acc;
    w_sum         = {1'b0, w_base} + {1'b0, w_prod};
    w_ovf         = SIGNED ? (w_base[MSB] == w_prod[MSB]) & (w_sum[MSB] != w_base[MSB]) : w_sum[ACC_WIDTH];
    // on signed overflow both addends share a sign, so the base sign picks the clamp direction
    w_res         = !(SATURATE && w_ovf) ? w_sum[ACC_WIDTH-1:0] :
                    !SIGNED ? '1 :
                    w_base[MSB] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    w_tile_ovf    = r_ovf | w_ovf;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_data_o  <= '0;
      a_valid_o <= 1'b0;
      a_last_o  <= 1'b0;
      b_data_o  <= '0;
      b_valid_o <= 1'b0;
      b_last_o  <= 1'b0;
      r_acc     <= '0;
      r_fresh   <= 1'b1;
      r_ovf     <= 1'b0;
      r_err     <= 1'b0;
      r_mem     <= '{default: '0};
      r_mem_ovf <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_cnt     <= '0;
    end else begin
      if (en_i) begin
        a_data_o  <= a_data_i;
        a_valid_o <= a_valid_i;
        a_last_o  <= a_last_i;
        b_data_o  <= b_data_i;
        b_valid_o <= b_valid_i;
        b_last_o  <= b_last_i;
      end
      if (w_fire) begin
        r_acc   <= w_res;
        r_fresh <= w_close;
        r_ovf   <= w_close ? 1'b0 : w_tile_ovf;
      end
      if (w_push_ok) begin
        r_mem[r_wptr]     <= w_res;
        r_mem_ovf[r_wptr] <= w_tile_ovf;
        r_wptr            <= r_wptr == PW'(DRAIN_DEPTH - 1) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr == PW'(DRAIN_DEPTH - 1) ? '0 : r_rptr + 1'b1;
      r_cnt <= r_cnt + CW'(w_push_ok) - CW'(w_pop);
      if (w_drop | w_mismatch) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pe_mac_param.sv
// tb_pe_mac_param: directed and randomized checks of pe_mac_param against an arithmetic reference model
module tb_pe_mac_param;
  localparam int DW = 8;
  localparam int AW = 24;
  localparam int DEPTH = 2;
  localparam longint MAXV = (64'sd1 <<< (AW - 1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (AW - 1));
  logic clk = 1'b0;
  logic rst, en, a_valid, a_last, b_valid, b_last, drain_ready;
  logic [DW-1:0] a_data, b_data;
  logic [DW-1:0] a_data_o, b_data_o;
  logic a_valid_o, a_last_o, b_valid_o, b_last_o;
  logic [AW-1:0] drain_data;
  logic drain_ovf, drain_valid, full, err;
  logic [DW-1:0] x_a_data [2];
  logic [DW-1:0] x_b_data [2];
  logic x_a_valid [2];
  logic x_a_last [2];
  logic x_b_valid [2];
  logic x_b_last [2];
  logic [15:0] x_data [2];
  logic x_ovf [2];
  logic x_valid [2];
  logic x_full [2];
  logic x_err [2];
  int total = 0;
  int bad = 0;
  longint m_acc;
  bit m_fresh, m_ovf, m_err;
  longint qd[$];
  bit qo[$];
  logic [DW-1:0] m_ad, m_bd;
  logic m_av, m_al, m_bv, m_bl;

  always #5 clk = ~clk;

  pe_mac_param #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SIGNED(1), .SATURATE(1), .DRAIN_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .a_data_i(a_data), .a_valid_i(a_valid), .a_last_i(a_last),
    .b_data_i(b_data), .b_valid_i(b_valid), .b_last_i(b_last),
    .a_data_o(a_data_o), .a_valid_o(a_valid_o), .a_last_o(a_last_o),
    .b_data_o(b_data_o), .b_valid_o(b_valid_o), .b_last_o(b_last_o),
    .drain_data_o(drain_data), .drain_ovf_o(drain_ovf), .drain_valid_o(drain_valid),
    .drain_ready_i(drain_ready), .full_o(full), .err_o(err)
  );

  for (genvar g = 0; g < 2; g++) begin : g_uns
    pe_mac_param #(.DATA_WIDTH(DW), .ACC_WIDTH(16), .SIGNED(0), .SATURATE(g == 0), .DRAIN_DEPTH(DEPTH)) dut_u (
      .clk_i(clk), .rst_i(rst), .en_i(en),
      .a_data_i(a_data), .a_valid_i(a_valid), .a_last_i(a_last),
      .b_data_i(b_data), .b_valid_i(b_valid), .b_last_i(b_last),
      .a_data_o(x_a_data[g]), .a_valid_o(x_a_valid[g]), .a_last_o(x_a_last[g]),
      .b_data_o(x_b_data[g]), .b_valid_o(x_b_valid[g]), .b_last_o(x_b_last[g]),
      .drain_data_o(x_data[g]), .drain_ovf_o(x_ovf[g]), .drain_valid_o(x_valid[g]),
      .drain_ready_i(drain_ready), .full_o(x_full[g]), .err_o(x_err[g])
    );
  end

  // advances the signed/saturating model by one clock using the currently applied inputs, then waits the edge
  task automatic cyc();
    bit fire, pop, ovf;
    longint s;
    pop = qd.size() != 0 && drain_ready;
    fire = en && a_valid && b_valid;
    if (rst) begin
      {m_ad, m_bd, m_av, m_al, m_bv, m_bl} = '0;
      m_acc = 0; m_fresh = 1; m_ovf = 0; m_err = 0;
      qd.delete(); qo.delete();
    end else begin
      if (en) {m_ad, m_bd, m_av, m_al, m_bv, m_bl} = {a_data, b_data, a_valid, a_last, b_valid, b_last};
      if (pop) begin void'(qd.pop_front()); void'(qo.pop_front()); end
      if (fire) begin
        s = (m_fresh ? 0 : m_acc) + longint'($signed(a_data)) * longint'($signed(b_data));
        ovf = 0;
        if (s > MAXV) begin ovf = 1; s = MAXV; end
        else if (s < MINV) begin ovf = 1; s = MINV; end
        if (a_last != b_last) m_err = 1;
        if (a_last && b_last) begin
          if (qd.size() < DEPTH) begin qd.push_back(s); qo.push_back(m_ovf | ovf); end
          else m_err = 1;
          m_fresh = 1; m_ovf = 0;
        end else begin
          m_fresh = 0; m_ovf = m_ovf | ovf;
        end
        m_acc = s;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic v, input logic al, input logic bl);
    en = e; a_data = a; b_data = b; a_valid = v; b_valid = v; a_last = al; b_last = bl;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    drain_ready = 0;
    rst = 1;
    cyc();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({a_data_o, a_valid_o, a_last_o, b_data_o, b_valid_o, b_last_o} !== '0) begin
      bad++; $display("FAIL reset_pass got=%0h exp=0", {a_data_o, a_valid_o, a_last_o, b_data_o, b_valid_o, b_last_o});
    end
    total++;
    if ({drain_data, drain_ovf, drain_valid, full, err} !== '0) begin
      bad++; $display("FAIL reset_drain got=%0h exp=0", {drain_data, drain_ovf, drain_valid, full, err});
    end
  endtask

  task automatic test_signed();
    do_reset();
    drive(1, 3, 4, 1, 0, 0); cyc();
    drive(1, -8'sd2, 5, 1, 0, 0); cyc();
    total++;
    if (drain_valid !== 1'b0) begin bad++; $display("FAIL signed_early_valid got=%0b exp=0", drain_valid); end
    drive(1, 7, -8'sd1, 1, 1, 1); cyc();
    drive(0, 0, 0, 0, 0, 0);
    total++;
    if ({drain_valid, drain_ovf, drain_data} !== {1'b1, 1'b0, 24'hFFFFFB}) begin
      bad++; $display("FAIL signed_result got=%0h exp=%0h", {drain_valid, drain_ovf, drain_data}, {1'b1, 1'b0, 24'hFFFFFB});
    end
    total++;
    if ({a_data_o, b_data_o, a_last_o} !== {8'd7, 8'hFF, 1'b1}) begin
      bad++; $display("FAIL signed_pass got=%0h exp=%0h", {a_data_o, b_data_o, a_last_o}, {8'd7, 8'hFF, 1'b1});
    end
    drain_ready = 1; cyc();
    total++;
    if (drain_valid !== 1'b0) begin bad++; $display("FAIL signed_pop got=%0b exp=0", drain_valid); end
  endtask

  task automatic test_stall();
    do_reset();
    drive(1, 3, 4, 1, 0, 0); cyc();
    for (int i = 0; i < 3; i++) begin
      drive(0, 8'd99 + 8'(i), 8'd50, 1, 1, 1); cyc();
      total++;
      if ({a_data_o, b_data_o, drain_valid} !== {8'd3, 8'd4, 1'b0}) begin
        bad++; $display("FAIL stall_hold got=%0h exp=%0h", {a_data_o, b_data_o, drain_valid}, {8'd3, 8'd4, 1'b0});
      end
    end
    drive(1, -8'sd2, 5, 1, 0, 0); cyc();
    drive(1, 7, -8'sd1, 1, 1, 1); cyc();
    drive(0, 0, 0, 0, 0, 0);
    total++;
    if ({drain_valid, drain_ovf, drain_data} !== {1'b1, 1'b0, 24'hFFFFFB}) begin
      bad++; $display("FAIL stall_result got=%0h exp=%0h", {drain_valid, drain_ovf, drain_data}, {1'b1, 1'b0, 24'hFFFFFB});
    end
  endtask

  task automatic test_unsigned();
    do_reset();
    drive(1, 255, 255, 1, 0, 0); cyc();
    drive(1, 255, 255, 1, 1, 1); cyc();
    drive(0, 0, 0, 0, 0, 0);
    total++;
    if ({x_valid[0], x_ovf[0], x_data[0]} !== {1'b1, 1'b1, 16'hFFFF}) begin
      bad++; $display("FAIL uns_sat got=%0h exp=%0h", {x_valid[0], x_ovf[0], x_data[0]}, {1'b1, 1'b1, 16'hFFFF});
    end
    total++;
    if ({x_valid[1], x_ovf[1], x_data[1]} !== {1'b1, 1'b1, 16'hFC02}) begin
      bad++; $display("FAIL uns_wrap got=%0h exp=%0h", {x_valid[1], x_ovf[1], x_data[1]}, {1'b1, 1'b1, 16'hFC02});
    end
    total++;
    if ({drain_ovf, drain_data} !== {1'b0, 24'd2}) begin
      bad++; $display("FAIL signed_neg1sq got=%0h exp=%0h", {drain_ovf, drain_data}, {1'b0, 24'd2});
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      drive(1, 8'(i), 1, 1, 1, 1); cyc();
      total++;
      if ({full, err} !== {i >= 2, i == 3}) begin
        bad++; $display("FAIL full_tile%0d got=%0b exp=%0b", i, {full, err}, {i >= 2, i == 3});
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    drain_ready = 1;
    for (int i = 1; i <= 2; i++) begin
      total++;
      if ({drain_valid, drain_data} !== {1'b1, 24'(i)}) begin
        bad++; $display("FAIL full_drain%0d got=%0h exp=%0h", i, {drain_valid, drain_data}, {1'b1, 24'(i)});
      end
      cyc();
    end
    total++;
    if ({drain_valid, full, err} !== 3'b001) begin
      bad++; $display("FAIL full_empty got=%0b exp=001", {drain_valid, full, err});
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1, 4, 1, 1, 1, 1); cyc();
    drive(1, 5, 1, 1, 1, 1); cyc();
    drain_ready = 1;
    drive(1, 6, 1, 1, 1, 1); cyc();
    drive(0, 0, 0, 0, 0, 0);
    total++;
    if ({err, full, drain_data} !== {1'b0, 1'b1, 24'd5}) begin
      bad++; $display("FAIL b2b_push_pop got=%0h exp=%0h", {err, full, drain_data}, {1'b0, 1'b1, 24'd5});
    end
    cyc();
    total++;
    if ({drain_valid, drain_data} !== {1'b1, 24'd6}) begin
      bad++; $display("FAIL b2b_order got=%0h exp=%0h", {drain_valid, drain_data}, {1'b1, 24'd6});
    end
    cyc();
    total++;
    if ({drain_valid, err} !== 2'b00) begin bad++; $display("FAIL b2b_empty got=%0b exp=00", {drain_valid, err}); end
  endtask

  task automatic test_mismatch();
    do_reset();
    drive(1, 9, 1, 1, 1, 0); cyc();
    drive(0, 0, 0, 0, 0, 0);
    total++;
    if ({err, drain_valid} !== 2'b10) begin bad++; $display("FAIL mismatch got=%0b exp=10", {err, drain_valid}); end
    rst = 1; cyc(); rst = 0;
    total++;
    if ({err, drain_valid} !== 2'b00) begin bad++; $display("FAIL mismatch_rst got=%0b exp=00", {err, drain_valid}); end
    drive(1, 2, 3, 1, 1, 1); cyc();
    drive(0, 0, 0, 0, 0, 0);
    total++;
    if ({drain_valid, drain_data} !== {1'b1, 24'd6}) begin
      bad++; $display("FAIL mismatch_fresh got=%0h exp=%0h", {drain_valid, drain_data}, {1'b1, 24'd6});
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] e;
    bit l;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      l = $urandom_range(0, 5) == 0;
      rst = $urandom_range(0, 99) == 0;
      drive($urandom_range(0, 4) != 0, 8'($urandom), 8'($urandom), $urandom_range(0, 3) != 0,
            l, $urandom_range(0, 40) == 0 ? !l : l);
      drain_ready = $urandom_range(0, 1);
      cyc();
      total++;
      if ({a_data_o, a_valid_o, a_last_o, b_data_o, b_valid_o, b_last_o} !== {m_ad, m_av, m_al, m_bd, m_bv, m_bl}) begin
        bad++; $display("FAIL rnd_pass cyc=%0d got=%0h exp=%0h", i,
          {a_data_o, a_valid_o, a_last_o, b_data_o, b_valid_o, b_last_o}, {m_ad, m_av, m_al, m_bd, m_bv, m_bl});
      end
      total++;
      if ({drain_valid, full, err} !== {qd.size() != 0, qd.size() == DEPTH, m_err}) begin
        bad++; $display("FAIL rnd_flags cyc=%0d got=%0b exp=%0b", i, {drain_valid, full, err},
          {qd.size() != 0, qd.size() == DEPTH, m_err});
      end
      if (qd.size() != 0) begin
        e = AW'(qd[0]);
        total++;
        if ({drain_ovf, drain_data} !== {qo[0], e}) begin
          bad++; $display("FAIL rnd_head cyc=%0d got=%0h exp=%0h", i, {drain_ovf, drain_data}, {qo[0], e});
        end
      end
    end
  endtask

  initial begin
    rst = 1;
    drive(0, 0, 0, 0, 0, 0);
    drain_ready = 0;
    test_reset();
    test_signed();
    test_stall();
    test_unsigned();
    test_full();
    test_back_to_back();
    test_mismatch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
